adder_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one fixed-latency pipelined adder (3-stage, one issue per cycle) between NUM_REQ requesters.
- Arbitrates requests and issues operands to the adder. Tracks each in-flight operation by requester tag through a shift register aligned with the adder pipeline, then routes each sum back to its originating requester.
- Sits between the requester front-ends and the shared adder instance in the accelerator datapath.

---
 rtl/adder_rr_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_adder_rr_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler
// Round-robin front end for one shared, fixed-latency pipelined adder.
// Each cycle at most one requester is granted. Its operands are registered
// towards the adder. Its tag travels through a shift register that is aligned
// with the adder pipeline, so that every sum is returned to the requester
// that issued it.
//
// Handshake: a requester raises req_valid[i] and holds req_a/req_b slice i
// stable. The operation transfers in the cycle where req_valid[i] and
// req_ready[i] are both 1. Responses have no backpressure. rsp_valid is a
// one-cycle pulse that the requester must accept.
//
// Optional build macro ADDER_RR_SCHED_STATS_EN adds per-requester saturating
// grant counters. They are read through stat_sel/stat_count.
module adder_rr_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int PIPE_LATENCY = 3
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst,
   input  logic                          arb_en,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic                          add_start,
   output logic [DATA_WIDTH-1:0]         add_a,
   output logic [DATA_WIDTH-1:0]         add_b,
   input  logic                          add_done,
   input  logic [DATA_WIDTH-1:0]         add_sum,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_sum,
   output logic                          ap_idle,
`ifdef ADDER_RR_SCHED_STATS_EN
   input  logic [$clog2(NUM_REQ)-1:0]    stat_sel,
   output logic [15:0]                   stat_count,
`endif
   output logic                          err_sync
);

   localparam int TAG_W = $clog2(NUM_REQ);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [TAG_W-1:0]      ptr_q, ptr_d;
   logic                  add_start_q, add_start_d;
   logic [DATA_WIDTH-1:0] add_a_q, add_a_d;
   logic [DATA_WIDTH-1:0] add_b_q, add_b_d;
   logic [TAG_W-1:0]      tag_q, tag_d;
   logic [PIPE_LATENCY-1:0] pipe_vld_q;
   logic [TAG_W-1:0]      pipe_tag_q [PIPE_LATENCY];
   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_sum_q, rsp_sum_d;
   logic                  err_q, err_d;

   // ------------------------------------------------------------------
   // Arbitration signals
   // ------------------------------------------------------------------
   logic                  grant_found;
   logic [TAG_W-1:0]      grant_idx;
   logic                  xfer;
   logic [DATA_WIDTH-1:0] sel_a;
   logic [DATA_WIDTH-1:0] sel_b;
   int                    cand;

   // Tail of the tag pipe, aligned with add_done
   logic                  tail_vld;
   logic [TAG_W-1:0]      tail_tag;
   logic                  rsp_fire;

   // Round-robin search starting at ptr; the first requesting index wins
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      req_ready   = '0;
      if (arb_en) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
               grant_found = 1'b1;
               grant_idx   = TAG_W'(cand);
            end
         end
      end
      if (grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // A grant is only given to an asserted request, so a grant is a transfer
   assign xfer = grant_found;

   // Pick the granted requester's operand slices
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == TAG_W'(i)) begin
            sel_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
            sel_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Next pointer, issue register and issue tag
   always_comb begin
      ptr_d       = ptr_q;
      add_start_d = xfer;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      tag_d       = tag_q;
      if (xfer) begin
         add_a_d = sel_a;
         add_b_d = sel_b;
         tag_d   = grant_idx;
         if (grant_idx == TAG_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = grant_idx + TAG_W'(1);
         end
      end
   end

   // Pointer and adder issue registers
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         ptr_q       <= '0;
         add_start_q <= 1'b0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         tag_q       <= '0;
      end else begin
         ptr_q       <= ptr_d;
         add_start_q <= add_start_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         tag_q       <= tag_d;
      end
   end

   // Tag pipe: stage 0 captures the issue strobe and tag being presented to
   // the adder, and the tail then lines up with that op's add_done
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         pipe_vld_q <= '0;
         for (int j = 0; j < PIPE_LATENCY; j++) begin
            pipe_tag_q[j] <= '0;
         end
      end else begin
         pipe_vld_q[0] <= add_start_q;
         pipe_tag_q[0] <= tag_q;
         for (int j = 1; j < PIPE_LATENCY; j++) begin
            pipe_vld_q[j] <= pipe_vld_q[j-1];
            pipe_tag_q[j] <= pipe_tag_q[j-1];
         end
      end
   end

   assign tail_vld = pipe_vld_q[PIPE_LATENCY-1];
   assign tail_tag = pipe_tag_q[PIPE_LATENCY-1];
   assign rsp_fire = tail_vld & add_done;

   // Route a matched sum to its requester; a lone tag or a lone done is an error
   always_comb begin
      rsp_valid_d = '0;
      rsp_sum_d   = rsp_sum_q;
      err_d       = err_q | (add_done != tail_vld);
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid_d[i] = rsp_fire && (tail_tag == TAG_W'(i));
      end
      if (rsp_fire) begin
         rsp_sum_d = add_sum;
      end
   end

   // Response and sticky error registers
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         rsp_valid_q <= '0;
         rsp_sum_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_sum_q   <= rsp_sum_d;
         err_q       <= err_d;
      end
   end

`ifdef ADDER_RR_SCHED_STATS_EN
   logic [15:0] cnt_q [NUM_REQ];
   logic [15:0] cnt_d [NUM_REQ];

   // Saturating per-requester grant counters
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         cnt_d[i] = cnt_q[i];
         if (xfer && (grant_idx == TAG_W'(i)) && (cnt_q[i] != 16'hFFFF)) begin
            cnt_d[i] = cnt_q[i] + 16'd1;
         end
      end
   end

   // Counter registers
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Combinational counter read; an out-of-range select reads zero
   always_comb begin
      stat_count = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (stat_sel == TAG_W'(i)) begin
            stat_count = cnt_q[i];
         end
      end
   end
`endif

   assign add_start = add_start_q;
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign err_sync  = err_q;
   assign ap_idle   = ~add_start_q & ~(|pipe_vld_q) & ~(|rsp_valid_q);

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: table-driven grant vectors, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_adder_rr_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int LAT  = 3;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b0;
  logic               arb_en;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic               add_start;
  logic [DW-1:0]      add_a;
  logic [DW-1:0]      add_b;
  logic               add_done;
  logic [DW-1:0]      add_sum;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_sum;
  logic               ap_idle;
  logic               err_sync;
`ifdef ADDER_RR_SCHED_STATS_EN
  logic [1:0]         stat_sel;
  logic [15:0]        stat_count;
`endif

  adder_rr_scheduler #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .PIPE_LATENCY(LAT)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_done  (add_done),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .ap_idle   (ap_idle),
`ifdef ADDER_RR_SCHED_STATS_EN
    .stat_sel  (stat_sel),
    .stat_count(stat_count),
`endif
    .err_sync  (err_sync)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // ---------------- requester operands ----------------
  logic [DW-1:0] op_a [NREQ];
  logic [DW-1:0] op_b [NREQ];
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW +: DW] = op_a[i];
      req_b[i*DW +: DW] = op_b[i];
    end
  end

  // ---------------- adder model (3-stage, shares reset) ----------------
  logic          inject_done = 1'b0;
  logic [LAT-1:0] am_v;
  logic [DW-1:0]  am_s [LAT];
  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      am_v <= '0;
    end else begin
      am_v[0] <= add_start;
      am_s[0] <= add_a + add_b;
      for (int j = 1; j < LAT; j++) begin
        am_v[j] <= am_v[j-1];
        am_s[j] <= am_s[j-1];
      end
    end
  end
  assign add_done = am_v[LAT-1] | inject_done;
  assign add_sum  = am_s[LAT-1];

  // ---------------- scoreboard ----------------
  // entry = {due cycle[31:0], tag[7:0], sum[31:0]}
  logic [71:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int m_ptr    = 0;
  logic [DW-1:0] hold_a = '0;
  logic [DW-1:0] hold_b = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  // Response monitor: every cycle the response bus must match the queue head
  // exactly when it is due, and be quiet otherwise
  initial begin
    logic [71:0] e;
    forever begin
      @(posedge ap_clk);
      #2;
      if (!ap_rst) begin
        if (exp_q.size() > 0 && exp_q[0][71:40] == 32'(cyc)) begin
          e = exp_q.pop_front();
          check("rsp_valid", 64'(rsp_valid), 64'(1) << e[39:32]);
          check("rsp_sum", 64'(rsp_sum), 64'(e[31:0]));
        end else begin
          check("rsp_quiet", 64'(rsp_valid), 64'd0);
        end
      end
    end
  end

  // Reference grant: first requesting index from ptr upwards, modulo NREQ
  function automatic logic [NREQ-1:0] model_grant(input logic en, input logic [NREQ-1:0] v);
    logic [NREQ-1:0] g;
    g = '0;
    if (en) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (v[(m_ptr + k) % NREQ]) g = NREQ'(1) << ((m_ptr + k) % NREQ);
      end
    end
    return g;
  endfunction

  // ---------------- driver tasks ----------------
  // Drives one cycle (called at posedge+1), checks the grant, records the
  // expected response and checks the issue registers after the edge
  task automatic apply(input logic en, input logic [NREQ-1:0] vld,
                       input logic [NREQ-1:0] exp_rdy, input string nm);
    logic x;
    arb_en    = en;
    req_valid = vld;
    #1;
    check(nm, 64'(req_ready), 64'(exp_rdy));
    x = |exp_rdy;
    if (x) begin
      for (int t = 0; t < NREQ; t++) begin
        if (exp_rdy[t]) begin
          hold_a = op_a[t];
          hold_b = op_b[t];
          exp_q.push_back({32'(cyc + 2 + LAT), 8'(t), DW'(op_a[t] + op_b[t])});
          m_ptr = (t + 1) % NREQ;
        end
      end
    end
    @(posedge ap_clk);
    #1;
    check("add_start", 64'(add_start), 64'(x));
    check("add_a", 64'(add_a), 64'(hold_a));
    check("add_b", 64'(add_b), 64'(hold_b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b1, '0, '0, "idle_grant");
  endtask

  task automatic do_reset();
    ap_rst      = 1'b1;
    arb_en      = 1'b0;
    req_valid   = '0;
    inject_done = 1'b0;
    #1;
    check("rst_add_start", 64'(add_start), 64'd0);
    check("rst_add_a", 64'(add_a), 64'd0);
    check("rst_add_b", 64'(add_b), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    check("rst_err_sync", 64'(err_sync), 64'd0);
    check("rst_ap_idle", 64'(ap_idle), 64'd1);
    exp_q.delete();
    m_ptr  = 0;
    hold_a = '0;
    hold_b = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
  endtask

  // ---------------- grant vector table ----------------
  typedef struct {
    logic            en;
    logic [NREQ-1:0] vld;
    logic [NREQ-1:0] rdy;
  } vec_t;
  vec_t tbl [10];

  initial begin
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] er;
    logic            en;

    // pointer evolution starting from 0 worked out row by row
    tbl[0] = '{1'b1, 4'b0000, 4'b0000};  // ptr 0
    tbl[1] = '{1'b1, 4'b0100, 4'b0100};  // ptr -> 3
    tbl[2] = '{1'b1, 4'b0011, 4'b0001};  // search 3,0 ; ptr -> 1
    tbl[3] = '{1'b1, 4'b1001, 4'b1000};  // search 1,2,3 ; ptr -> 0
    tbl[4] = '{1'b0, 4'b1111, 4'b0000};  // disabled ; ptr 0
    tbl[5] = '{1'b1, 4'b1111, 4'b0001};  // ptr -> 1
    tbl[6] = '{1'b1, 4'b0001, 4'b0001};  // search wraps to 0 ; ptr -> 1
    tbl[7] = '{1'b1, 4'b0110, 4'b0010};  // ptr -> 2
    tbl[8] = '{1'b1, 4'b1010, 4'b1000};  // ptr -> 0
    tbl[9] = '{1'b1, 4'b1110, 4'b0010};  // ptr -> 2

    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
`ifdef ADDER_RR_SCHED_STATS_EN
    stat_sel = '0;
`endif

    // ---- table vectors ----
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = $urandom();
      op_b[i] = $urandom();
    end
    for (int r = 0; r < 10; r++) apply(tbl[r].en, tbl[r].vld, tbl[r].rdy, $sformatf("tbl_grant_%0d", r));
    idle(8);

    // ---- single op: requester 2, 5+7 ----
    do_reset();
    op_a[2] = 32'd5;
    op_b[2] = 32'd7;
    check("single_idle_before", 64'(ap_idle), 64'd1);
    apply(1'b1, 4'b0100, 4'b0100, "single_grant");
    check("single_busy", 64'(ap_idle), 64'd0);
    idle(4);
    check("single_rsp_valid", 64'(rsp_valid), 64'b0100);
    check("single_rsp_sum", 64'(rsp_sum), 64'd12);
    idle(1);
    check("single_idle_after", 64'(ap_idle), 64'd1);

    // ---- full contention: strict rotation, no bubbles ----
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 32'd1000 + 32'(i);
      op_b[i] = 32'(i * 3);
    end
    for (int k = 0; k < 8; k++) apply(1'b1, 4'b1111, 4'b0001 << (k % NREQ), "rr_grant");
    idle(7);
    check("rr_drained", 64'(exp_q.size()), 64'd0);

    // ---- wrap and overflow ----
    do_reset();
    op_a[3] = 32'hFFFF_FFFF;
    op_b[3] = 32'd2;
    op_a[1] = 32'd40;
    op_b[1] = 32'd2;
    apply(1'b1, 4'b1000, 4'b1000, "wrap_grant3");
    apply(1'b1, 4'b0010, 4'b0010, "wrap_grant1");
    idle(3);
    check("wrap_rsp_valid", 64'(rsp_valid), 64'b1000);
    check("wrap_rsp_sum", 64'(rsp_sum), 64'd1);
    idle(4);

    // ---- arb_en drop with three ops in flight ----
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = $urandom();
      op_b[i] = $urandom();
    end
    apply(1'b1, 4'b0001, 4'b0001, "drop_grant0");
    apply(1'b1, 4'b0010, 4'b0010, "drop_grant1");
    apply(1'b1, 4'b0100, 4'b0100, "drop_grant2");
    for (int k = 0; k < 8; k++) apply(1'b0, 4'b1111, 4'b0000, "drop_no_grant");
    check("drop_drained", 64'(exp_q.size()), 64'd0);
    check("drop_idle", 64'(ap_idle), 64'd1);
    check("drop_err", 64'(err_sync), 64'd0);

    // ---- reset mid-flight: in-flight results must never appear ----
    do_reset();
    apply(1'b1, 4'b0001, 4'b0001, "mid_grant0");
    apply(1'b1, 4'b0010, 4'b0010, "mid_grant1");
    apply(1'b1, 4'b0000, 4'b0000, "mid_gap");
    do_reset();
    idle(10);
    check("mid_err", 64'(err_sync), 64'd0);
    check("mid_idle", 64'(ap_idle), 64'd1);

    // ---- spurious add_done with an empty pipe ----
    do_reset();
    check("sync_err_before", 64'(err_sync), 64'd0);
    inject_done = 1'b1;
    apply(1'b1, '0, '0, "sync_idle");
    inject_done = 1'b0;
    check("sync_err_set", 64'(err_sync), 64'd1);
    idle(5);
    check("sync_err_sticky", 64'(err_sync), 64'd1);

`ifdef ADDER_RR_SCHED_STATS_EN
    // ---- grant counters ----
    do_reset();
    for (int k = 0; k < 5; k++) apply(1'b1, 4'b0001, 4'b0001, "stat_grant");
    stat_sel = 2'd0;
    #1;
    check("stat_count0", 64'(stat_count), 64'd5);
    stat_sel = 2'd1;
    #1;
    check("stat_count1", 64'(stat_count), 64'd0);
    idle(7);
`endif

    // ---- randomized traffic against the model ----
    do_reset();
    pend = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          op_a[i] = $urandom();
          op_b[i] = $urandom();
        end
      end
      en = ($urandom_range(0, 7) != 0);
      er = model_grant(en, pend);
      apply(en, pend, er, "rand_grant");
      pend = pend & ~er;
    end
    idle(8);
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_err", 64'(err_sync), 64'd0);
    check("rand_idle", 64'(ap_idle), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
